// File: rtl/ic_bvugt_bvshl_witness_search_if.sv
// ---------------------------------------------------------------------------
// ic_bvugt_bvshl_witness_search_if
// Bundles the request/response handshake of the bvugt/bvshl witness search.
//
// Handshake rules (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds its payload stable while valid=1 and ready=0.
//   In this block valid never depends on ready.
//
// Signals:
//   req_valid   requester -> block   request present, s_in/t_in valid
//   req_ready   block -> requester   block can accept a request
//   s_in        requester -> block   shift amount s (W bits, unsigned)
//   t_in        requester -> block   comparison bound t (W bits, unsigned)
//   rsp_valid   block -> consumer    result valid
//   rsp_ready   consumer -> block    consumer accepts result
//   rsp_found   block -> consumer    1 = witness exists
//   rsp_witness block -> consumer    smallest witness x, 0 when none
//   ic_mismatch block -> consumer    search result disagrees with closed form
//
// Modports: master = requester/consumer side, slave = search block.
// ---------------------------------------------------------------------------
interface ic_bvugt_bvshl_witness_search_if #(
   parameter int W = 4
);
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] s_in;
   logic [W-1:0] t_in;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_found;
   logic [W-1:0] rsp_witness;
   logic         ic_mismatch;

   modport master (
      output req_valid, s_in, t_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_found, rsp_witness, ic_mismatch
   );

   modport slave (
      input  req_valid, s_in, t_in, rsp_ready,
      output req_ready, rsp_valid, rsp_found, rsp_witness, ic_mismatch
   );
endinterface

// File: rtl/ic_bvugt_bvshl_witness_search.sv
// ---------------------------------------------------------------------------
// ic_bvugt_bvshl_witness_search
// Brute-force search for the smallest x such that (x << s) >u t, all W bits.
// Used to validate synthesized Skolem functions for bvugt/bvshl on chip.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   bus       slave modport of ic_bvugt_bvshl_witness_search_if
//             (req_valid/req_ready/s_in/t_in, rsp_valid/rsp_ready/
//              rsp_found/rsp_witness, ic_mismatch)
//   state_dbg out  current FSM state (0=IDLE, 1=SEARCH, 2=DONE)
//
// Optional feature (macro IC_CROSSCHECK_EN): when defined, the search result
// is compared with the closed-form invertibility condition
// t <u (~0 << s) and ic_mismatch flags disagreement while in DONE.
// When undefined, ic_mismatch is constant 0 and no IC logic exists.
//
// Timing: witness k -> rsp_valid k+1 edges after the accept edge;
// no solution -> rsp_valid 2^W edges after the accept edge.
// All outputs come from registers; no input-to-output combinational path.
// ---------------------------------------------------------------------------
module ic_bvugt_bvshl_witness_search #(
   parameter int W = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   ic_bvugt_bvshl_witness_search_if.slave        bus,
   output logic [1:0]                            state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   // W as a W-bit value; W < 2^W for every legal W, so it always fits.
   localparam logic [W-1:0] W_L = W'(W);

   state_t       state, state_next;
   logic [W-1:0] s_q, t_q, x_cnt;
   logic [W-1:0] s_next, t_next, x_next;
   logic         found_q, found_next;
   logic [W-1:0] witness_q, witness_next;
   logic [W-1:0] prod;
   logic         hit;
   logic         last_x;

   // Candidate product; shifts of W or more clear every bit.
   always_comb begin
      prod = '0;
      if (s_q < W_L) prod = x_cnt << s_q;
   end

   assign hit    = (prod > t_q);
   assign last_x = (x_cnt == {W{1'b1}});

   // Next-state and datapath updates.
   always_comb begin
      state_next   = state;
      s_next       = s_q;
      t_next       = t_q;
      x_next       = x_cnt;
      found_next   = found_q;
      witness_next = witness_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               s_next     = bus.s_in;
               t_next     = bus.t_in;
               x_next     = '0;
               state_next = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               found_next   = 1'b1;
               witness_next = x_cnt;
               state_next   = DONE;
            end else if (last_x) begin
               // Exhausted the space; x_cnt stays at all-ones rather than wrapping.
               found_next   = 1'b0;
               witness_next = '0;
               state_next   = DONE;
            end else begin
               x_next = x_cnt + 1'b1;
            end
         end
         DONE: begin
            if (bus.rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s_q       <= '0;
         t_q       <= '0;
         x_cnt     <= '0;
         found_q   <= 1'b0;
         witness_q <= '0;
      end else begin
         state     <= state_next;
         s_q       <= s_next;
         t_q       <= t_next;
         x_cnt     <= x_next;
         found_q   <= found_next;
         witness_q <= witness_next;
      end
   end

   assign bus.req_ready   = (state == IDLE);
   assign bus.rsp_valid   = (state == DONE);
   assign bus.rsp_found   = found_q;
   assign bus.rsp_witness = witness_q;
   assign state_dbg       = state;

`ifdef IC_CROSSCHECK_EN
   logic [W-1:0] ic_limit;
   logic         ic_now;
   logic         ic_q;
   logic         mismatch_q;

   // A witness exists iff the largest reachable product (~0 << s) exceeds t.
   always_comb begin
      ic_limit = '0;
      if (s_q < W_L) ic_limit = {W{1'b1}} << s_q;
   end
   assign ic_now = (t_q < ic_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ic_q       <= 1'b0;
         mismatch_q <= 1'b0;
      end else if (state == SEARCH && state_next == DONE) begin
         ic_q       <= ic_now;
         mismatch_q <= (ic_now != found_next);
      end else if (state == DONE && state_next == IDLE) begin
         mismatch_q <= 1'b0;
      end
   end

   // Gate by DONE so the flag is only visible alongside a response.
   assign bus.ic_mismatch = (state == DONE) && mismatch_q && (ic_q == ~found_q);
`else
   assign bus.ic_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_ic_bvugt_bvshl_witness_search.sv
module tb_ic_bvugt_bvshl_witness_search;
  localparam int W = 4;
  localparam int SPACE = 1 << W;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  ic_bvugt_bvshl_witness_search_if #(.W(W)) bus ();

  ic_bvugt_bvshl_witness_search #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan every x in order using plain integer arithmetic.
  task automatic model(input int s, input int t, output bit found, output int witness,
                       output int lat);
    found = 1'b0;
    witness = 0;
    lat = SPACE;
    for (int x = 0; x < SPACE; x++) begin
      int p;
      p = (s >= W) ? 0 : ((x << s) % SPACE);
      if (p > t) begin
        found = 1'b1;
        witness = x;
        lat = x + 1;
        break;
      end
    end
  endtask

  // Driver: present a request, return edges from accept to rsp_valid.
  task automatic drive_req(input int s, input int t, output int lat, output bit got);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_req: got %b expected 1", bus.req_ready);
    end
    bus.s_in = s[W-1:0];
    bus.t_in = t[W-1:0];
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < SPACE + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid === 1'b1) got = 1'b1;
    end
  endtask

  // One complete transaction with all response and release checks.
  task automatic test_request(input int s, input int t, input string tag);
    bit e_found, got;
    int e_wit, e_lat, lat;
    model(s, t, e_found, e_wit, e_lat);
    drive_req(s, t, lat, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout s=%0d t=%0d: no rsp_valid within %0d edges", tag, s, t, lat);
      return;
    end
    checks++;
    if (lat !== e_lat) begin
      errors++;
      $display("FAIL %s_latency s=%0d t=%0d: got %0d expected %0d", tag, s, t, lat, e_lat);
    end
    checks++;
    if (bus.rsp_found !== e_found) begin
      errors++;
      $display("FAIL %s_found s=%0d t=%0d: got %b expected %b", tag, s, t, bus.rsp_found, e_found);
    end
    checks++;
    if (bus.rsp_witness !== e_wit[W-1:0]) begin
      errors++;
      $display("FAIL %s_witness s=%0d t=%0d: got %0d expected %0d", tag, s, t,
               bus.rsp_witness, e_wit);
    end
    checks++;
    if (bus.ic_mismatch !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_flags s=%0d t=%0d: ic_mismatch=%b req_ready=%b expected 0/0",
               tag, s, t, bus.ic_mismatch, bus.req_ready);
    end
    // Release the response and confirm the return to IDLE with held results.
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_found !== e_found ||
        bus.rsp_witness !== e_wit[W-1:0]) begin
      errors++;
      $display("FAIL %s_release: valid=%b ready=%b found=%b wit=%0d expected 0 1 %b %0d",
               tag, bus.rsp_valid, bus.req_ready, bus.rsp_found, bus.rsp_witness, e_found, e_wit);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_found !== 1'b0 ||
        bus.rsp_witness !== '0 || bus.ic_mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b found=%b wit=%0d ic=%b expected 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_found, bus.rsp_witness, bus.ic_mismatch);
    end
  endtask

  task automatic test_directed();
    int s_tab[5] = '{0, 1, 3, 5, 2};
    int t_tab[5] = '{5, 13, 8, 0, 15};
    for (int i = 0; i < 5; i++) test_request(s_tab[i], t_tab[i], "directed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int s, t;
      s = $urandom_range(SPACE - 1, 0);
      t = $urandom_range(SPACE - 1, 0);
      test_request(s, t, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) test_request($urandom_range(3, 0), $urandom_range(SPACE - 1, 0), "b2b");
  endtask

  task automatic test_backpressure();
    int lat;
    bit got;
    drive_req(0, 5, lat, got);
    checks++;
    if (!got || lat !== 7) begin
      errors++;
      $display("FAIL bp_latency: got %0d (valid seen=%b) expected 7", lat, got);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.s_in = 4'd3;
      bus.t_in = 4'd8;
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== 1'b1 || bus.rsp_witness !== 4'd6 ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b found=%b wit=%0d ready=%b expected 1 1 6 0",
                 c, bus.rsp_valid, bus.rsp_found, bus.rsp_witness, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 1", bus.rsp_valid, bus.req_ready);
    end
    // The ignored request must not have been latched.
    test_request(1, 13, "bp_next");
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    @(negedge clk);
    bus.s_in = 4'd3;
    bus.t_in = 4'd8;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_found !== 1'b0 ||
        bus.rsp_witness !== '0 || bus.ic_mismatch !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: ready=%b valid=%b found=%b wit=%0d ic=%b expected 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_found, bus.rsp_witness, bus.ic_mismatch);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (SPACE + 4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_no_response: got rsp_valid=1 expected no response");
    end
    test_request(0, 0, "post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.s_in = '0;
    bus.t_in = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
